// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Request/response sequencer for a 16-bit combinational ALU.
//               Registers operands, waits SETTLE cycles, captures result/flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int WIDTH  = 16,
    parameter int OPW    = 3,
    parameter int SETTLE = 1,
    parameter int CNTW   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OPW-1:0]   req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_n,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_z,
    output logic             rsp_v,
    output logic             rsp_n,
    output logic [2:0]       ccr,
    output logic             v_sticky,
    input  logic             clr_sticky,
    output logic [CNTW-1:0]  op_count,
    output logic             busy
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] c_settle_last = CW'(SETTLE - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_drive = 2'd1;
    localparam logic [1:0] c_resp  = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          w_accept;
    logic          w_rsp_hs;
    logic          w_capture;

    assign w_accept  = req_valid && req_ready;
    assign w_rsp_hs  = rsp_valid && rsp_ready;
    assign w_capture = (r_state == c_drive) && (r_cnt == c_settle_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (w_accept) w_state_nxt = c_drive;
            end
            c_drive: begin
                if (w_capture) w_state_nxt = c_resp;
            end
            c_resp: begin
                // A new request may be taken on the same edge the response leaves.
                if (w_rsp_hs) w_state_nxt = w_accept ? c_drive : c_idle;
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        req_ready = !rst && ((r_state == c_idle) || ((r_state == c_resp) && rsp_ready));
        busy      = (r_state != c_idle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_z     <= 1'b0;
            rsp_v     <= 1'b0;
            rsp_n     <= 1'b0;
            ccr       <= 3'b000;
            v_sticky  <= 1'b0;
            op_count  <= '0;
        end else begin
            if (w_accept) begin
                alu_op <= req_op;
                alu_a  <= req_a;
                alu_b  <= req_b;
                r_cnt  <= '0;
            end else if ((r_state == c_drive) && !w_capture) begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_capture) begin
                rsp_data  <= alu_out;
                rsp_z     <= alu_z;
                rsp_v     <= alu_v;
                rsp_n     <= alu_n;
                ccr       <= {alu_n, alu_v, alu_z};
                rsp_valid <= 1'b1;
            end else if (w_rsp_hs) begin
                rsp_valid <= 1'b0;
            end

            if (w_rsp_hs) op_count <= op_count + CNTW'(1);

            // Setting by a captured overflow takes priority over the clear.
            if (w_capture && alu_v) begin
                v_sticky <= 1'b1;
            end else if (clr_sticky) begin
                v_sticky <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_ctrl
// Description : Directed scoreboard bench for alu_seq_ctrl with an ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_out;
    logic        alu_z;
    logic        alu_v;
    logic        alu_n;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_z;
    logic        rsp_v;
    logic        rsp_n;
    logic [2:0]  ccr;
    logic        v_sticky;
    logic        clr_sticky;
    logic [15:0] op_count;
    logic        busy;

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_z(rsp_z), .rsp_v(rsp_v), .rsp_n(rsp_n),
        .ccr(ccr), .v_sticky(v_sticky), .clr_sticky(clr_sticky),
        .op_count(op_count), .busy(busy)
    );

    // Stand-in for the combinational ALU: only add is exercised here.
    always_comb begin
        alu_out = 16'h0000;
        alu_v   = 1'b0;
        if (alu_op == 3'b000) begin
            alu_out = alu_a + alu_b;
            alu_v   = (alu_a[15] == alu_b[15]) && (alu_out[15] != alu_a[15]);
        end
        alu_z = (alu_out == 16'h0000);
        alu_n = alu_out[15];
    end

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic        z;
        logic        v;
        logic        n;
    } req_t;

    req_t        pend[$];
    req_t        sb[$];
    int          checks    = 0;
    int          failures  = 0;
    int          n_pops    = 0;
    int          cyc       = 0;
    logic [15:0] exp_count = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_next();
        if (pend.size() > 0) begin
            req_valid = 1'b1;
            req_op    = pend[0].op;
            req_a     = pend[0].a;
            req_b     = pend[0].b;
        end else begin
            req_valid = 1'b0;
            req_op    = 3'h7;
            req_a     = 16'hDEAD;
            req_b     = 16'hBEEF;
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] d,
                         input logic z, input logic v, input logic n);
        req_t r;
        r = '{op: 3'b000, a: a, b: b, d: d, z: z, v: v, n: n};
        pend.push_back(r);
        if (!req_valid) load_next();
    endtask

    // One clock: observe handshakes at the falling edge, then advance past the rising edge.
    task automatic step();
        logic acc;
        logic hs;
        req_t e;
        @(negedge clk);
        acc = req_valid && req_ready;
        hs  = rsp_valid && rsp_ready;
        if (rst) begin
            sb.delete();
            exp_count = 16'h0000;
        end else begin
            if (hs) begin
                checks++;
                assert (sb.size() > 0) else begin
                    failures++;
                    $error("FAIL rsp_unexpected observed=0x%0h expected=none", rsp_data);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rsp_data", {16'h0, rsp_data}, {16'h0, e.d});
                    chk("rsp_flags", {29'h0, rsp_n, rsp_v, rsp_z}, {29'h0, e.n, e.v, e.z});
                    chk("ccr", {29'h0, ccr}, {29'h0, e.n, e.v, e.z});
                end
                n_pops++;
                exp_count = exp_count + 16'h1;
            end
            if (acc) sb.push_back(pend.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
        load_next();
        chk("op_count", {16'h0, op_count}, {16'h0, exp_count});
    endtask

    task automatic wait_rsp(input string tag, output int at_cyc);
        int  start;
        logic got;
        start = n_pops;
        got   = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (n_pops > start) begin
                got    = 1'b1;
                at_cyc = cyc;
            end
        end
        checks++;
        assert (got) else begin
            failures++;
            $error("FAIL %s_timeout observed=no_response expected=response", tag);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2, c3;
        logic [15:0] cnt0;
        rst = 1'b1; req_valid = 1'b0; req_op = 3'h0; req_a = 16'h0; req_b = 16'h0;
        rsp_ready = 1'b1; clr_sticky = 1'b0;
        step(); step();
        chk("reset_req_ready", {31'h0, req_ready}, 32'h0);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_ccr", {29'h0, ccr}, 32'h0);
        chk("reset_v_sticky", {31'h0, v_sticky}, 32'h0);
        chk("reset_alu_a", {16'h0, alu_a}, 32'h0);
        chk("reset_rsp_data", {16'h0, rsp_data}, 32'h0);
        rst = 1'b0;
        step();

        // Case 1: latency of two edges from accept to rsp_valid
        issue(16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
        step();
        chk("c1_busy_after_accept", {31'h0, busy}, 32'h1);
        chk("c1_rsp_valid_edge1", {31'h0, rsp_valid}, 32'h0);
        chk("c1_alu_a", {16'h0, alu_a}, 32'h1);
        step();
        chk("c1_rsp_valid_edge2", {31'h0, rsp_valid}, 32'h1);
        wait_rsp("c1", c1);
        step();
        chk("c1_idle", {31'h0, busy}, 32'h0);

        // Case 2: signed overflow sets the sticky bit
        issue(16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1);
        wait_rsp("c2", c1);
        chk("c2_v_sticky", {31'h0, v_sticky}, 32'h1);

        // Case 3: zero result, sticky persists until cleared
        issue(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
        wait_rsp("c3", c1);
        chk("c3_v_sticky_held", {31'h0, v_sticky}, 32'h1);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        chk("c3_v_sticky_cleared", {31'h0, v_sticky}, 32'h0);

        // Case 4: response held under back-pressure with another request waiting
        rsp_ready = 1'b0;
        cnt0 = op_count;
        issue(16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0, 1'b1);
        issue(16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0);
        step(); step();
        for (int i = 0; i < 5; i++) begin
            chk("c4_rsp_valid_hold", {31'h0, rsp_valid}, 32'h1);
            chk("c4_rsp_data_hold", {16'h0, rsp_data}, 32'hFFFE);
            chk("c4_rsp_n_hold", {31'h0, rsp_n}, 32'h1);
            chk("c4_req_ready_low", {31'h0, req_ready}, 32'h0);
            step();
        end
        chk("c4_count_held", {16'h0, op_count}, {16'h0, cnt0});
        rsp_ready = 1'b1;
        wait_rsp("c4a", c1);
        chk("c4_count_once", {16'h0, op_count}, {16'h0, cnt0 + 16'h1});
        wait_rsp("c4b", c1);

        // Case 5: three queued requests stream at one response per two cycles
        cnt0 = op_count;
        issue(16'h1234, 16'h0101, 16'h1335, 1'b0, 1'b0, 1'b0);
        issue(16'h4000, 16'h4000, 16'h8000, 1'b0, 1'b1, 1'b1);
        issue(16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0);
        wait_rsp("c5a", c1);
        wait_rsp("c5b", c2);
        wait_rsp("c5c", c3);
        chk("c5_spacing_12", c2 - c1, 32'd2);
        chk("c5_spacing_23", c3 - c2, 32'd2);
        chk("c5_count_plus3", {16'h0, op_count}, {16'h0, cnt0 + 16'h3});

        // Case 6: reset during DRIVE abandons the operation
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        issue(16'h0005, 16'h0005, 16'h000A, 1'b0, 1'b0, 1'b0);
        step();
        chk("c6_in_drive", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        pend.delete();
        step();
        chk("c6_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("c6_busy", {31'h0, busy}, 32'h0);
        chk("c6_ccr", {29'h0, ccr}, 32'h0);
        chk("c6_op_count", {16'h0, op_count}, 32'h0);
        rst = 1'b0;
        step(); step();
        chk("c6_no_late_rsp", {31'h0, rsp_valid}, 32'h0);
        chk("c6_ccr_after", {29'h0, ccr}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
